// File: rtl/gtx_test_seq_pkg.sv
// Shared types and phase-length helpers for the multi-channel GTX TX test sequencer.
// Phase lengths are derived from the counter width and the fast-rate shift.
package gtx_test_seq_pkg;

    localparam int CTR_W_DEF      = 11;
    localparam int FAST_SHIFT_DEF = 4;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        PULSE_HI  = 3'd2,
        PULSE_LO  = 3'd3,
        DONE      = 3'd4,
        READY     = 3'd5
    } state_t;

    function automatic int settle_len(input logic rate,
                                      input int ctr_w = CTR_W_DEF,
                                      input int fast_shift = FAST_SHIFT_DEF);
        int len;
        len = 32'sd1 <<< (ctr_w - 1);
        return rate ? (len >>> fast_shift) : len;
    endfunction

    function automatic int half_len(input logic rate,
                                    input int ctr_w = CTR_W_DEF,
                                    input int fast_shift = FAST_SHIFT_DEF);
        int len;
        len = 32'sd1 <<< (ctr_w - 3);
        return rate ? (len >>> fast_shift) : len;
    endfunction

endpackage

// File: rtl/gtx_test_seq_ch.sv
// One GTX TX test channel: lock synchroniser, phase FSM with down-counter and
// a saturating count of lock-loss restarts. Outputs are registered from next state.
module gtx_test_seq_ch
    import gtx_test_seq_pkg::*;
#(
    parameter int CTR_W      = CTR_W_DEF,
    parameter int FAST_SHIFT = FAST_SHIFT_DEF,
    parameter int NPULSE     = 2,
    parameter int DONE_LEN   = 4,
    parameter int SYNC_STG   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       plllkdet,
    input  logic       tx_rate,
    input  logic       init,
    output logic       gtxtest_bit1,
    output logic       gtxtest_done,
    output logic       ch_ready,
    output logic [7:0] restart_cnt
);

    localparam int PC_W = $clog2(NPULSE + 1);
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] SETTLE0  = CTR_W'(settle_len(1'b0, CTR_W, FAST_SHIFT) - 1);
    localparam logic [CTR_W-1:0] SETTLE1  = CTR_W'(settle_len(1'b1, CTR_W, FAST_SHIFT) - 1);
    localparam logic [CTR_W-1:0] HALF0    = CTR_W'(half_len(1'b0, CTR_W, FAST_SHIFT) - 1);
    localparam logic [CTR_W-1:0] HALF1    = CTR_W'(half_len(1'b1, CTR_W, FAST_SHIFT) - 1);
    localparam logic [CTR_W-1:0] DONE_LD  = CTR_W'(DONE_LEN - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(NPULSE - 1);

    logic [SYNC_STG-1:0] sync_r;
    logic                lock_s;
    state_t              state_r, state_s;
    logic [CTR_W-1:0]    ctr_r, ctr_s;
    logic [CTR_W-1:0]    half_s;
    logic [PC_W-1:0]     pcnt_r, pcnt_s;
    logic                rate_r, rate_s;
    logic [7:0]          rcnt_r, rcnt_s;
    logic                bit1_r, done_r, ready_r;

    assign lock_s = sync_r[SYNC_STG-1];
    assign half_s = rate_r ? HALF1 : HALF0;

    // Next-state, phase counter, pulse counter, rate latch and restart count.
    always_comb begin
        state_s = state_r;
        ctr_s   = ctr_r;
        pcnt_s  = pcnt_r;
        rate_s  = rate_r;
        if (!lock_s || init) begin
            state_s = WAIT_LOCK;
            ctr_s   = CTR_ZERO;
            pcnt_s  = {PC_W{1'b0}};
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    state_s = SETTLE;
                    rate_s  = tx_rate;
                    ctr_s   = tx_rate ? SETTLE1 : SETTLE0;
                    pcnt_s  = {PC_W{1'b0}};
                end
                SETTLE: begin
                    if (ctr_r == CTR_ZERO) begin
                        state_s = PULSE_HI;
                        ctr_s   = half_s;
                    end else begin
                        ctr_s = ctr_r - {{(CTR_W-1){1'b0}}, 1'b1};
                    end
                end
                PULSE_HI: begin
                    if (ctr_r == CTR_ZERO) begin
                        state_s = PULSE_LO;
                        ctr_s   = half_s;
                    end else begin
                        ctr_s = ctr_r - {{(CTR_W-1){1'b0}}, 1'b1};
                    end
                end
                PULSE_LO: begin
                    if (ctr_r == CTR_ZERO) begin
                        pcnt_s = pcnt_r + {{(PC_W-1){1'b0}}, 1'b1};
                        if (pcnt_r == PC_LAST) begin
                            state_s = DONE;
                            ctr_s   = DONE_LD;
                        end else begin
                            state_s = PULSE_HI;
                            ctr_s   = half_s;
                        end
                    end else begin
                        ctr_s = ctr_r - {{(CTR_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (ctr_r == CTR_ZERO) begin
                        state_s = READY;
                    end else begin
                        ctr_s = ctr_r - {{(CTR_W-1){1'b0}}, 1'b1};
                    end
                end
                READY: begin
                    state_s = READY;
                end
                default: begin
                    state_s = WAIT_LOCK;
                    ctr_s   = CTR_ZERO;
                    pcnt_s  = {PC_W{1'b0}};
                end
            endcase
        end
        // INIT alone is a restart but not a lock loss, so only !lock_s counts.
        if (!lock_s && (state_r != WAIT_LOCK) && (rcnt_r != 8'hFF)) begin
            rcnt_s = rcnt_r + 8'd1;
        end else begin
            rcnt_s = rcnt_r;
        end
    end

    // State, synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= {SYNC_STG{1'b0}};
            state_r <= WAIT_LOCK;
            ctr_r   <= CTR_ZERO;
            pcnt_r  <= {PC_W{1'b0}};
            rate_r  <= 1'b0;
            rcnt_r  <= 8'd0;
            bit1_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STG-2:0], plllkdet};
            state_r <= state_s;
            ctr_r   <= ctr_s;
            pcnt_r  <= pcnt_s;
            rate_r  <= rate_s;
            rcnt_r  <= rcnt_s;
            bit1_r  <= (state_s == PULSE_HI);
            done_r  <= (state_s == DONE);
            ready_r <= (state_s == READY);
        end
    end

    assign gtxtest_bit1 = bit1_r;
    assign gtxtest_done = done_r;
    assign ch_ready     = ready_r;
    assign restart_cnt  = rcnt_r;

endmodule

// File: rtl/gtx_test_seq_multi.sv
// Multi-channel GTX TX test/reset sequencer: NCH independent channel sequencers
// plus a registered all-channels-ready flag.
module gtx_test_seq_multi
    import gtx_test_seq_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CTR_W      = CTR_W_DEF,
    parameter int FAST_SHIFT = FAST_SHIFT_DEF,
    parameter int NPULSE     = 2,
    parameter int DONE_LEN   = 4,
    parameter int SYNC_STG   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH-1:0]   PLLLKDET,
    input  logic [NCH-1:0]   TX_RATE,
    input  logic [NCH-1:0]   INIT,
    output logic [NCH-1:0]   GTXTEST_BIT1,
    output logic [NCH-1:0]   GTXTEST_DONE,
    output logic [NCH-1:0]   CH_READY,
    output logic             ALL_READY,
    output logic [8*NCH-1:0] RESTART_CNT
);

    logic all_ready_r;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gtx_test_seq_ch #(
            .CTR_W      (CTR_W),
            .FAST_SHIFT (FAST_SHIFT),
            .NPULSE     (NPULSE),
            .DONE_LEN   (DONE_LEN),
            .SYNC_STG   (SYNC_STG)
        ) u_ch (
            .clk          (CLK),
            .rst          (RST),
            .plllkdet     (PLLLKDET[i]),
            .tx_rate      (TX_RATE[i]),
            .init         (INIT[i]),
            .gtxtest_bit1 (GTXTEST_BIT1[i]),
            .gtxtest_done (GTXTEST_DONE[i]),
            .ch_ready     (CH_READY[i]),
            .restart_cnt  (RESTART_CNT[8*i +: 8])
        );
    end

    // Combined ready, one cycle behind the per-channel flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            all_ready_r <= 1'b0;
        end else begin
            all_ready_r <= &CH_READY;
        end
    end

    assign ALL_READY = all_ready_r;

endmodule

// File: tb/tb_gtx_test_seq_multi.sv
// Directed bench for gtx_test_seq_multi: expected output edges are queued per channel
// when stimulus is applied and checked by a negedge monitor as the DUT produces them.
module tb_gtx_test_seq_multi;

    localparam int NCH    = 4;
    localparam int CTR_W  = 11;
    localparam int FS     = 4;
    localparam int NPULSE = 2;
    localparam int DL     = 4;
    localparam int S      = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NCH-1:0]   PLLLKDET, TX_RATE, INIT;
    logic [NCH-1:0]   GTXTEST_BIT1, GTXTEST_DONE, CH_READY;
    logic             ALL_READY;
    logic [8*NCH-1:0] RESTART_CNT;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    // Edge kinds: 0/1 BIT1 rise/fall, 2/3 DONE rise/fall, 4/5 READY rise/fall.
    ev_t q[NCH+1][$];
    int  cyc      = 0;
    int  n_assert = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    int  exp_rc[NCH];
    logic [NCH-1:0] bit1_p, done_p, rdy_p;
    logic           all_p;

    gtx_test_seq_multi #(
        .NCH(NCH), .CTR_W(CTR_W), .FAST_SHIFT(FS),
        .NPULSE(NPULSE), .DONE_LEN(DL), .SYNC_STG(S)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PLLLKDET     (PLLLKDET),
        .TX_RATE      (TX_RATE),
        .INIT         (INIT),
        .GTXTEST_BIT1 (GTXTEST_BIT1),
        .GTXTEST_DONE (GTXTEST_DONE),
        .CH_READY     (CH_READY),
        .ALL_READY    (ALL_READY),
        .RESTART_CNT  (RESTART_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int ch, input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        q[ch].push_back(e);
    endtask

    // Queue a full sequence whose first lock_s cycle is l; returns the CH_READY rise cycle.
    task automatic push_seq(input int ch, input int l, input bit rate, output int rdy);
        int set, h, b;
        set = (1 << (CTR_W - 1)) >> (rate ? FS : 0);
        h   = (1 << (CTR_W - 3)) >> (rate ? FS : 0);
        b   = l + 1 + set;
        for (int k = 0; k < NPULSE; k++) begin
            push(ch, 0, b + 2 * h * k);
            push(ch, 1, b + 2 * h * k + h);
        end
        b = b + 2 * h * NPULSE;
        push(ch, 2, b);
        push(ch, 3, b + DL);
        push(ch, 4, b + DL);
        rdy = b + DL;
    endtask

    function automatic int qtotal();
        int n;
        n = 0;
        for (int i = 0; i <= NCH; i++) n += q[i].size();
        return n;
    endfunction

    task automatic wait_empty(input int bound);
        int left;
        left = bound;
        while (left > 0 && qtotal() != 0) begin
            step(1);
            left--;
        end
        chk("drain_pending_events", qtotal(), 0);
        for (int i = 0; i <= NCH; i++) q[i].delete();
    endtask

    task automatic mon_edge(input int ch, input int kind);
        ev_t   e;
        string tag;
        tag = (ch == NCH) ? "all_ready_edge" : $sformatf("ch%0d_edge", ch);
        if (q[ch].size() == 0) begin
            chk({tag, "_unexpected"}, kind * 100000 + cyc, -1);
        end else begin
            e = q[ch].pop_front();
            chk(tag, kind * 100000 + cyc, e.kind * 100000 + e.cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (GTXTEST_BIT1[i] !== bit1_p[i]) mon_edge(i, GTXTEST_BIT1[i] ? 0 : 1);
                if (GTXTEST_DONE[i] !== done_p[i]) mon_edge(i, GTXTEST_DONE[i] ? 2 : 3);
                if (CH_READY[i] !== rdy_p[i])      mon_edge(i, CH_READY[i] ? 4 : 5);
            end
            if (ALL_READY !== all_p) mon_edge(NCH, ALL_READY ? 4 : 5);
        end
        bit1_p <= GTXTEST_BIT1;
        done_p <= GTXTEST_DONE;
        rdy_p  <= CH_READY;
        all_p  <= ALL_READY;
    end

    task automatic check_rc();
        for (int i = 0; i < NCH; i++)
            chk($sformatf("restart_cnt%0d", i), int'(RESTART_CNT[8*i +: 8]), exp_rc[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bit1"},  int'(GTXTEST_BIT1), 0);
        chk({tag, "_done"},  int'(GTXTEST_DONE), 0);
        chk({tag, "_ready"}, int'(CH_READY), 0);
        chk({tag, "_all"},   int'(ALL_READY), 0);
        chk({tag, "_rcnt"},  int'(RESTART_CNT), 0);
    endtask

    initial begin
        int t, t2, r, rr;
        RST      = 1'b1;
        PLLLKDET = '0;
        TX_RATE  = '0;
        INIT     = '0;
        for (int i = 0; i < NCH; i++) exp_rc[i] = 0;

        // Reset state.
        step(3);
        @(negedge CLK);
        check_zero("reset");
        step(1);
        RST    = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Full-rate sequences, staggered locks; ALL_READY follows the last channel.
        t = cyc;
        PLLLKDET[0] = 1'b1;
        push_seq(0, t + S, 1'b0, r);
        for (int i = 1; i < NCH; i++) begin
            step(3);
            PLLLKDET[i] = 1'b1;
            push_seq(i, cyc + S, 1'b0, r);
        end
        push(NCH, 4, r + 1);
        wait_empty(2300);
        chk("all_ready_after_rate0", int'(ALL_READY), 1);
        chk("ch_ready_after_rate0", int'(CH_READY), 15);

        // Lock loss on all channels, then shortened timing everywhere.
        t = cyc;
        PLLLKDET = '0;
        for (int i = 0; i < NCH; i++) begin
            push(i, 5, t + S + 1);
            exp_rc[i]++;
        end
        push(NCH, 5, t + S + 2);
        step(5);
        TX_RATE  = 4'hF;
        PLLLKDET = 4'hF;
        t2 = cyc;
        for (int i = 0; i < NCH; i++) push_seq(i, t2 + S, 1'b1, r);

        // Drop channel 1 lock while it is in its first high pulse.
        step(68);
        chk("ch1_bit1_before_drop", int'(GTXTEST_BIT1[1]), 1);
        PLLLKDET[1] = 1'b0;
        q[1].delete();
        push(1, 1, cyc + S + 1);
        exp_rc[1]++;
        step(10);
        PLLLKDET[1] = 1'b1;
        push_seq(1, cyc + S, 1'b1, r);
        push(NCH, 4, r + 1);
        wait_empty(400);
        check_rc();

        // INIT in READY restarts channel 2 without counting a lock loss.
        step(5);
        t = cyc;
        INIT[2] = 1'b1;
        push(2, 5, t + 1);
        push(NCH, 5, t + 2);
        step(1);
        INIT[2] = 1'b0;
        push_seq(2, t + 1, 1'b1, r);
        push(NCH, 4, r + 1);
        wait_empty(300);
        check_rc();

        // Rate latched at sequence start: toggling TX_RATE[0] in SETTLE has no effect.
        step(5);
        t = cyc;
        PLLLKDET[0] = 1'b0;
        TX_RATE[0]  = 1'b0;
        push(0, 5, t + S + 1);
        push(NCH, 5, t + S + 2);
        exp_rc[0]++;
        step(5);
        PLLLKDET[0] = 1'b1;
        push_seq(0, cyc + S, 1'b0, r);
        push(NCH, 4, r + 1);
        step(20);
        TX_RATE[0] = 1'b1;
        wait_empty(2300);
        check_rc();

        // Repeated lock loss on channel 3 saturates its restart counter.
        step(5);
        PLLLKDET[3] = 1'b0;
        push(3, 5, cyc + S + 1);
        push(NCH, 5, cyc + S + 2);
        exp_rc[3]++;
        step(4);
        for (int k = 0; k < 300; k++) begin
            PLLLKDET[3] = 1'b1;
            step(3);
            PLLLKDET[3] = 1'b0;
            step(3);
            exp_rc[3] = (exp_rc[3] < 255) ? exp_rc[3] + 1 : 255;
        end
        wait_empty(20);
        check_rc();

        // Reset mid-sequence clears outputs and counts; sequences then rerun.
        PLLLKDET[3] = 1'b1;
        push_seq(3, cyc + S, 1'b1, r);
        step(71);
        chk("ch3_bit1_before_rst", int'(GTXTEST_BIT1[3]), 1);
        RST = 1'b1;
        rr  = cyc;
        for (int i = 0; i <= NCH; i++) q[i].delete();
        push(3, 1, rr + 1);
        for (int i = 0; i < NCH - 1; i++) push(i, 5, rr + 1);
        step(1);
        RST = 1'b0;
        @(negedge CLK);
        check_zero("mid_rst");
        for (int i = 0; i < NCH; i++) begin
            exp_rc[i] = 0;
            push_seq(i, rr + S + 1, TX_RATE[i], r);
        end
        push(NCH, 4, r + 1);
        wait_empty(400);
        check_rc();
        chk("all_ready_final", int'(ALL_READY), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
